// File: rtl/nexys_btn_pkg.sv
// Shared constants for the Nexys pushbutton conditioner: button indices,
// last_dir codes, per-button FSM states and the step-to-direction encoder.
package nexys_btn_pkg;

  localparam int NUM_BTN = 5;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  localparam logic [2:0] DIR_NONE = 3'd0;
  localparam logic [2:0] DIR_C    = 3'd1;
  localparam logic [2:0] DIR_U    = 3'd2;
  localparam logic [2:0] DIR_D    = 3'd3;
  localparam logic [2:0] DIR_L    = 3'd4;
  localparam logic [2:0] DIR_R    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_t;

  // Lowest-index asserted step wins, so later assignments override earlier ones.
  function automatic logic [2:0] step_to_dir(input logic [NUM_BTN-1:0] step);
    logic [2:0] dir;
    dir = DIR_NONE;
    if (step[BTN_R]) dir = DIR_R;
    if (step[BTN_L]) dir = DIR_L;
    if (step[BTN_D]) dir = DIR_D;
    if (step[BTN_U]) dir = DIR_U;
    if (step[BTN_C]) dir = DIR_C;
    return dir;
  endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// One pushbutton: 2-flop synchronizer, debounce counter, and the
// IDLE/HOLD/REPEAT step generator with its auto-repeat counter.
//
// state     | meaning
// ST_IDLE   | debounced level low, waiting for a press
// ST_HOLD   | press stepped, counting down the initial repeat delay
// ST_REPEAT | auto-repeating every REPEAT_RATE cycles while held
module btn_debounce_fsm
  import nexys_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic step
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;
  localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LOAD = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0] RATE_LOAD  = RPT_W'(REPEAT_RATE - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [DB_W-1:0]  db_cnt;
  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_nxt;
  logic             step_nxt;
  btn_state_t       state;
  btn_state_t       state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Any agreeing sample restarts the run; the level flips on the run's last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (sync_q2 == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      level  <= ~level;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rpt_cnt <= '0;
      step    <= 1'b0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
      step    <= step_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    step_nxt    = 1'b0;
    if (!level) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          step_nxt    = 1'b1;
          state_nxt   = ST_HOLD;
          rpt_cnt_nxt = DELAY_LOAD;
        end
        ST_HOLD, ST_REPEAT: begin
          // With auto-repeat disabled the counter stays frozen in HOLD.
          if (REPEAT_EN) begin
            if (rpt_cnt == '0) begin
              step_nxt    = 1'b1;
              state_nxt   = ST_REPEAT;
              rpt_cnt_nxt = RATE_LOAD;
            end else begin
              rpt_cnt_nxt = rpt_cnt - RPT_W'(1);
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Five independent debounced/auto-repeating pushbuttons plus a register
// remembering the direction of the most recent step.
module button_conditioner
  import nexys_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BTN-1:0]   btn_in,
  output logic [NUM_BTN-1:0]   btn_level,
  output logic [NUM_BTN-1:0]   btn_step,
  output logic [2:0]           last_dir
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : gen_btn
    btn_debounce_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_btn (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_in[i]),
      .level   (btn_level[i]),
      .step    (btn_step[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dir <= DIR_NONE;
    end else if (|btn_step) begin
      last_dir <= step_to_dir(btn_step);
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a default-repeat build and a no-repeat build
// share one stimulus and are compared against a window/arithmetic reference model.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RR = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_in;
  logic [4:0] btn_level, btn_step;
  logic [2:0] last_dir;
  logic [4:0] btn_level_b, btn_step_b;
  logic [2:0] last_dir_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level), .btn_step(btn_step), .last_dir(last_dir)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(0), .REPEAT_RATE(RR)) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(btn_level_b), .btn_step(btn_step_b), .last_dir(last_dir_b)
  );

  // Reference model: a level flips once the last DB synchronized samples all
  // disagree with it; steps are scheduled arithmetically from the press edge.
  int         rd_cfg [2] = '{RD, 0};
  logic [4:0] m_s1, m_s2, m_level, m_lvl_prev, m_sample;
  logic [4:0] m_step [2];
  logic [4:0] m_step_prev [2];
  logic [2:0] m_dir [2];
  bit         m_held [2][5];
  int         m_press [2][5];
  bit         m_hist [5][$];
  int         m_t, m_e;
  bit         m_all_diff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_t = 0;
      for (int i = 0; i < 2; i++) begin
        m_step[i] = '0; m_dir[i] = '0;
        for (int b = 0; b < 5; b++) m_held[i][b] = 1'b0;
      end
      for (int b = 0; b < 5; b++) m_hist[b].delete();
    end else begin
      m_t++;
      m_lvl_prev = m_level;
      m_step_prev[0] = m_step[0];
      m_step_prev[1] = m_step[1];
      m_sample = m_s2; m_s2 = m_s1; m_s1 = btn_in;
      for (int b = 0; b < 5; b++) begin
        m_hist[b].push_back(m_sample[b]);
        if (m_hist[b].size() > DB) void'(m_hist[b].pop_front());
        m_all_diff = (m_hist[b].size() == DB);
        foreach (m_hist[b][j]) if (m_hist[b][j] == m_lvl_prev[b]) m_all_diff = 1'b0;
        if (m_all_diff) m_level[b] = ~m_lvl_prev[b];
      end
      for (int i = 0; i < 2; i++) begin
        for (int b = 0; b < 5; b++) begin
          if (!m_lvl_prev[b]) begin
            m_held[i][b] = 1'b0; m_step[i][b] = 1'b0;
          end else if (!m_held[i][b]) begin
            m_held[i][b] = 1'b1; m_press[i][b] = m_t; m_step[i][b] = 1'b1;
          end else begin
            m_e = m_t - m_press[i][b];
            m_step[i][b] = (rd_cfg[i] > 0) && (m_e >= rd_cfg[i]) && ((m_e - rd_cfg[i]) % RR == 0);
          end
        end
        if (m_step_prev[i] != '0)
          for (int b = 4; b >= 0; b--) if (m_step_prev[i][b]) m_dir[i] = 3'(b + 1);
      end
    end
  end

  // Tasks run aligned to 1 ns after a rising edge.
  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_in = '0;
    #2;
    n_tests++;
    if ({btn_level, btn_step, last_dir, btn_level_b, btn_step_b, last_dir_b} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%b/%b/%0d exp=0", btn_level, btn_step, last_dir);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    btn_in = 5'b00010;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (btn_level[1] !== (k >= 5) || btn_step[1] !== (k == 6)) begin
        n_fail++;
        $display("FAIL clean_press edge=%0d got lvl=%b stp=%b exp lvl=%b stp=%b",
                 k, btn_level[1], btn_step[1], k >= 5, k == 6);
      end
      n_tests++;
      if ({btn_level, btn_step, last_dir} !== {m_level, m_step[0], m_dir[0]}) begin
        n_fail++;
        $display("FAIL clean_model edge=%0d got=%b/%b/%0d exp=%b/%b/%0d",
                 k, btn_level, btn_step, last_dir, m_level, m_step[0], m_dir[0]);
      end
    end
    n_tests++;
    if (last_dir !== 3'd2) begin
      n_fail++;
      $display("FAIL clean_last_dir got=%0d exp=2", last_dir);
    end
    btn_in = '0;
    settle(12);
  endtask

  task automatic test_bounce();
    pulse_reset();
    for (int k = 0; k < 30; k++) begin
      btn_in[3] = (k < 20) && (k % 3 != 2);
      @(posedge clk); #1;
      n_tests++;
      if ({btn_level, btn_step, last_dir} !== 13'd0 || btn_step_b !== 5'd0) begin
        n_fail++;
        $display("FAIL bounce edge=%0d got=%b/%b/%0d exp=0", k, btn_level, btn_step, last_dir);
      end
    end
    btn_in = '0;
  endtask

  task automatic test_auto_repeat();
    bit exp_a;
    pulse_reset();
    btn_in = 5'b10000;
    for (int k = 0; k < 56; k++) begin
      @(posedge clk); #1;
      exp_a = (k == 6) || (k >= 14 && k <= 45 && (k - 14) % 3 == 0);
      n_tests++;
      if (btn_step[4] !== exp_a || btn_step_b[4] !== (k == 6)) begin
        n_fail++;
        $display("FAIL auto_repeat edge=%0d got=%b/%b exp=%b/%b",
                 k, btn_step[4], btn_step_b[4], exp_a, k == 6);
      end
      n_tests++;
      if ({btn_step, last_dir} !== {m_step[0], m_dir[0]} ||
          {btn_step_b, last_dir_b} !== {m_step[1], m_dir[1]}) begin
        n_fail++;
        $display("FAIL repeat_model edge=%0d got=%b/%0d exp=%b/%0d",
                 k, btn_step, last_dir, m_step[0], m_dir[0]);
      end
      if (k == 39) btn_in[4] = 1'b0;
    end
    n_tests++;
    if (last_dir !== 3'd5) begin
      n_fail++;
      $display("FAIL repeat_last_dir got=%0d exp=5", last_dir);
    end
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    btn_in = 5'b10100;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (btn_step[2] !== btn_step[4] || btn_step[2] !== (k == 6)) begin
        n_fail++;
        $display("FAIL simultaneous edge=%0d got=%b exp_both=%b", k, btn_step, k == 6);
      end
    end
    n_tests++;
    if (last_dir !== 3'd3) begin
      n_fail++;
      $display("FAIL simul_last_dir got=%0d exp=3", last_dir);
    end
    btn_in = '0;
    settle(14);
  endtask

  task automatic test_reset_mid_hold();
    pulse_reset();
    btn_in = 5'b00001;
    for (int k = 0; k <= 12; k++) begin @(posedge clk); #1; end
    n_tests++;
    if (last_dir !== 3'd1 || btn_level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset got dir=%0d lvl=%b exp dir=1 lvl=1", last_dir, btn_level[0]);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({btn_level, btn_step, last_dir, btn_level_b, btn_step_b, last_dir_b} !== 26'd0) begin
      n_fail++;
      $display("FAIL async_reset got=%b/%b/%0d exp=0", btn_level, btn_step, last_dir);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #1;
      n_tests++;
      if (btn_step[0] !== (j == 7) || btn_step !== m_step[0]) begin
        n_fail++;
        $display("FAIL rehold_step edge=%0d got=%b exp=%b model=%b", j, btn_step[0], j == 7, m_step[0]);
      end
    end
    btn_in = '0;
    settle(14);
  endtask

  task automatic test_random();
    pulse_reset();
    for (int k = 0; k < 600; k++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 9) == 0) btn_in[b] = ~btn_in[b];
      @(posedge clk); #1;
      n_tests++;
      if ({btn_level, btn_step, last_dir} !== {m_level, m_step[0], m_dir[0]} ||
          {btn_level_b, btn_step_b, last_dir_b} !== {m_level, m_step[1], m_dir[1]}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%b/%b/%0d b=%b/%0d exp=%b/%b/%0d b=%b/%0d",
                 k, btn_level, btn_step, last_dir, btn_step_b, last_dir_b,
                 m_level, m_step[0], m_dir[0], m_step[1], m_dir[1]);
      end
    end
    btn_in = '0;
    settle(14);
  endtask

  task automatic test_no_repeat_build();
    int pulses = 0;
    pulse_reset();
    btn_in = 5'b00010;
    for (int k = 0; k < 62; k++) begin
      if (k == 50) btn_in = '0;
      @(posedge clk); #1;
      if (btn_step_b[1]) pulses++;
    end
    n_tests++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL no_repeat_pulses got=%0d exp=1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    test_no_repeat_build();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
